// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester-side and ROM-side signals of rom_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requesters and the ROM.
interface rom_arbiter_if #(parameter int size_addr = 8);
  logic                 m0_req, m1_req, m0_ack, m1_ack;
  logic [size_addr-1:0] m0_addr, m1_addr;
  logic [1:0]           m0_len, m1_len;
  logic [31:0]          m0_data, m1_data;
  logic                 rom_read, rom_ready;
  logic [size_addr-1:0] rom_address;
  logic [7:0]           rom_data;
  modport master (
    output m0_req, m0_addr, m0_len, m1_req, m1_addr, m1_len, rom_ready, rom_data,
    input  m0_ack, m0_data, m1_ack, m1_data, rom_read, rom_address
  );
  modport slave (
    input  m0_req, m0_addr, m0_len, m1_req, m1_addr, m1_len, rom_ready, rom_data,
    output m0_ack, m0_data, m1_ack, m1_data, rom_read, rom_address
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one 8-bit ROM read port between fetch (port 0) and load (port 1),
// assembling 1-4 bytes little-endian. Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module rom_arbiter #(parameter int size_addr = 8) (
  input logic clk,
  input logic rst_n,
  rom_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [size_addr-1:0] base_q, base_d, rom_address_q, rom_address_d;
  logic [2:0]           n_q, n_d, ic_q, ic_d, rc_q, rc_d;
  logic [31:0]          res_q, res_d, m0_data_q, m0_data_d, m1_data_q, m1_data_d;
  logic                 rom_read_q, rom_read_d, m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                 cap, sel1;
`ifdef ROM_ARB_FIXED_PRIO_EN
  assign sel1 = bus.m1_req & ~bus.m0_req;
`else
  logic last_q, last_d;
  // last_q = 1 means port 1 was served last, so port 0 wins the next tie
  assign sel1 = bus.m1_req & (~bus.m0_req | ~last_q);
  assign last_d = (state_q == DONE) ? owner_q : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  // bytes arriving while idle are stale and dropped
  assign cap = (state_q != IDLE) & bus.rom_ready & (rc_q < n_q);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d = base_q;
    n_d = n_q;
    ic_d = ic_q;
    rc_d = cap ? rc_q + 3'd1 : rc_q;
    res_d = res_q;
    if (cap) res_d[{rc_q[1:0], 3'b000} +: 8] = bus.rom_data;
    rom_read_d = rom_read_q;
    rom_address_d = rom_address_q;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    m0_data_d = m0_data_q;
    m1_data_d = m1_data_q;
    case (state_q)
      IDLE: if (bus.m0_req | bus.m1_req) begin
        state_d = ISSUE;
        owner_d = sel1;
        base_d = sel1 ? bus.m1_addr : bus.m0_addr;
        n_d = {1'b0, (sel1 ? bus.m1_len : bus.m0_len)} + 3'd1;
        ic_d = '0;
        rc_d = '0;
        res_d = '0;
        rom_read_d = 1'b1;
        rom_address_d = base_d;
      end
      ISSUE: begin
        ic_d = ic_q + 3'd1;
        rom_read_d = ic_d < n_q;
        rom_address_d = base_q + size_addr'(ic_d);
        state_d = (ic_d < n_q) ? ISSUE : DRAIN;
      end
      DRAIN: if (cap && rc_d == n_q) begin
        state_d = DONE;
        m0_ack_d = ~owner_q;
        m1_ack_d = owner_q;
        m0_data_d = owner_q ? m0_data_q : res_d;
        m1_data_d = owner_q ? res_d : m1_data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      base_q <= '0;
      n_q <= '0;
      ic_q <= '0;
      rc_q <= '0;
      res_q <= '0;
      rom_read_q <= 1'b0;
      rom_address_q <= '0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q <= base_d;
      n_q <= n_d;
      ic_q <= ic_d;
      rc_q <= rc_d;
      res_q <= res_d;
      rom_read_q <= rom_read_d;
      rom_address_q <= rom_address_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
      m0_data_q <= m0_data_d;
      m1_data_q <= m1_data_d;
    end
  assign bus.rom_read = rom_read_q;
  assign bus.rom_address = rom_address_q;
  assign bus.m0_ack = m0_ack_q;
  assign bus.m1_ack = m1_ack_q;
  assign bus.m0_data = m0_data_q;
  assign bus.m1_data = m1_data_q;
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single 8-bit `rom` read port between two requesters: port 0 (instruction fetch) and port 1 (data load). Each request reads 1–4 consecutive bytes, which the block assembles little-endian into a 32-bit word. Reads are issued back-to-back, one per cycle, to exploit the ROM's one-cycle latency. Sits between the fetch/load units and `rom`, and is the only driver of `rom`'s `read`/`address`.

## Interface
- `size_addr`, default 8, ROM address width; must match `rom.size_addr`.
- `clk` in 1: clock; all state changes on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req` in 1: port 0 request; held high until `m0_ack`.
- `m0_addr` in size_addr: port 0 start byte address; sampled at grant.
- `m0_len` in 2: port 0 byte count minus 1 (0..3 means 1..4 bytes); sampled at grant.
- `m0_ack` out 1: one-cycle pulse when `m0_data` is valid.
- `m0_data` out 32: port 0 result; unread upper bytes are 0; held until the next port 0 ack.
- `m1_req`, `m1_addr`, `m1_len`, `m1_ack`, `m1_data`: identical for port 1.
- `rom_read` out 1: drives `rom.read`.
- `rom_address` out size_addr: drives `rom.address`.
- `rom_ready` in 1: from `rom.ready`.
- `rom_data` in 8: from `rom.data`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if any `mX_req` is high, grant one port. Latch `owner`, `base`, `n = len+1`. Clear the result register, the issue count `ic` and the receive count `rc`. Go to ISSUE.
- Arbitration is round-robin. With both requesting, grant the port not served last. A single requester is granted immediately. After reset, "last served" = 1, so port 0 wins the first tie.
- ISSUE: `rom_read=1`, `rom_address = base + ic` (mod 2^size_addr, wraps 0xFF→0x00 at default width), `ic++`. After issuing the n-th read, go to DRAIN.
- Capture happens in any non-IDLE state: when `rom_ready=1`, write `rom_data` into byte `rc` of the result (bits 8*rc+7:8*rc) and `rc++`.
- DRAIN: `rom_read=0`. When the capture makes `rc == n`, go to DONE.
- DONE: pulse `owner`'s ack for one cycle. Copy the result into `mX_data`. Toggle "last served" to `owner`. Return to IDLE.
- A requester must drop `req` in the cycle after its ack. A `req` still high in the following IDLE is treated as a new request.
- `rom_ready` in IDLE is ignored.
- `mX_addr`/`mX_len` changes after grant have no effect.
- The non-owner's `req` is ignored until IDLE; its data and ack are untouched.

## Timing
- All outputs are registered. Reset values: `rom_read=0`, `rom_address=0`, `m0_ack=m1_ack=0`, `m0_data=m1_data=0`, state IDLE, `ic=rc=0`, last served=1.
- Request seen in IDLE cycle 0:
  - `rom_read` is high in cycles 1..n.
  - `rom_ready` is high in cycles 2..n+1.
  - Ack is high in cycle n+2.
  - IDLE is re-entered in cycle n+3.
- Request-to-ack latency is n+2 cycles: 3 for 1 byte, 6 for 4 bytes. Port occupancy is n+3 cycles.
- Peak throughput is one ROM byte per cycle within a request, with a 3-cycle gap between requests.
- `rst_n` low mid-transfer: everything clears immediately (asynchronously). The partial result is discarded and no ack is issued. Late `rom_ready` pulses arrive in IDLE and are ignored. The requester re-arbitrates after reset release.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins ties, and the last-served register is not built.
- Undefined (default): round-robin as described above.

## Test plan
- Single byte: ROM[0x10]=0xA5; `m0_req`, addr 0x10, len 0 → `rom_read` only in cycle 1 with address 0x10; `m0_ack` in cycle 3; `m0_data`=0x000000A5.
- Four-byte word: ROM[0x20..0x23]=11,22,33,44; `m1_req`, len 3 → addresses 0x20..0x23 on consecutive cycles 1–4; `m1_ack` in cycle 6; `m1_data`=0x44332211.
- Wrap-around: ROM[0xFE]=0x01, ROM[0xFF]=0x02, ROM[0x00]=0x03; addr 0xFE, len 2 → addresses FE, FF, 00; data=0x00030201.
- Contention: both ports request in the same cycle after reset and hold → port 0 is served first, then port 1, then port 0 again, alternating. Under `ROM_ARB_FIXED_PRIO_EN`, port 0 is always served.
- Reset mid-transfer: 4-byte port 0 request, `rst_n` low in cycle 3 for 1 cycle → `rom_read`=0 immediately; no `m0_ack`; `m0_data` stays 0. After release, the held request completes normally with the correct data.
- Stray ready: `rom_ready` pulsed with 0xFF while in IDLE → no state change, no ack, data unchanged.
